acc_write_sequencer: RTL and testbench

- Controller for the accumulator write side of the matrix-multiply unit.
- Accepts matrix-multiply instructions (accumulator base address, row count, accumulate/overwrite flag) over a valid/ready handshake.
- Issues one row per enabled cycle into the systolic array and delays a per-row write descriptor by the array latency, so each result row reaches the accumulator with the correct address and accumulate flag.
- Back-to-back instructions are supported, with a per-instruction done pulse.

---
 rtl/acc_write_sequencer_if.sv | 33 +++
 rtl/acc_write_sequencer.sv | 120 ++++++++++++
 tb/tb_acc_write_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/acc_write_sequencer_if.sv
// acc_write_sequencer_if: instruction, issue and accumulator-write signals of the accumulator write sequencer
//   master: drives enable and the instruction offer, observes everything else
//   slave : the sequencer; accepts instructions, drives issue/write/status
interface acc_write_sequencer_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 32
);
    logic                  enable;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [ADDR_WIDTH-1:0] instr_acc_addr;
    logic [LEN_WIDTH-1:0]  instr_length;
    logic                  instr_accumulate;
    logic                  issue_valid;
    logic                  issue_first;
    logic                  acc_wr_en;
    logic [ADDR_WIDTH-1:0] acc_wr_addr;
    logic                  acc_wr_accumulate;
    logic                  done;
    logic                  busy;

    modport master (
        output enable, instr_valid, instr_acc_addr, instr_length, instr_accumulate,
        input  instr_ready, issue_valid, issue_first, acc_wr_en, acc_wr_addr,
               acc_wr_accumulate, done, busy
    );

    modport slave (
        input  enable, instr_valid, instr_acc_addr, instr_length, instr_accumulate,
        output instr_ready, issue_valid, issue_first, acc_wr_en, acc_wr_addr,
               acc_wr_accumulate, done, busy
    );
endinterface

// File: rtl/acc_write_sequencer.sv
// acc_write_sequencer: issues matrix-multiply rows into the systolic array and
// emits the matching accumulator writes PIPE_DELAY enabled cycles later.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of acc_write_sequencer_if
//              enable           global enable, low freezes every register
//              instr_*          instruction handshake (base, length, accumulate)
//              issue_valid/first row entering the array / row 0 marker
//              acc_wr_*         delayed accumulator write descriptor
//              done             pulse on the last write of an instruction
//              busy             instruction active or rows in flight
module acc_write_sequencer #(
    parameter int ADDR_WIDTH   = 16,
    parameter int LEN_WIDTH    = 32,
    parameter int MATRIX_WIDTH = 14,
    parameter int PIPE_DELAY   = 2 * MATRIX_WIDTH + 3
) (
    input logic                    clk,
    input logic                    rst,
    acc_write_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic                  acc_q, acc_d;
    logic [LEN_WIDTH-1:0]  row_q, row_d;

    // Delay line: stage 0 receives the descriptor pushed this cycle,
    // stage PIPE_DELAY-1 is the head presented to the accumulator.
    logic [PIPE_DELAY-1:0] pipe_valid_q, pipe_valid_d;
    logic [PIPE_DELAY-1:0] pipe_last_q, pipe_last_d;
    logic [PIPE_DELAY-1:0] pipe_acc_q, pipe_acc_d;
    logic [ADDR_WIDTH-1:0] pipe_addr_q [PIPE_DELAY];
    logic [ADDR_WIDTH-1:0] pipe_addr_d [PIPE_DELAY];

    logic last_row;
    logic instr_ready;
    logic issuing;
    logic accept;
    logic load;
    logic head_valid;

    assign last_row    = row_q == len_q - LEN_WIDTH'(1);
    assign instr_ready = ~rst & ((state_q != RUN) | last_row);
    assign issuing     = ~rst & bus.enable & (state_q == RUN);
    assign accept      = bus.instr_valid & instr_ready & bus.enable;
    // Zero-length instructions complete the handshake but leave no trace.
    assign load        = accept & (bus.instr_length != '0);
    assign head_valid  = pipe_valid_q[PIPE_DELAY-1];

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        len_d        = len_q;
        acc_d        = acc_q;
        row_d        = row_q;
        pipe_valid_d = pipe_valid_q;
        pipe_last_d  = pipe_last_q;
        pipe_acc_d   = pipe_acc_q;
        pipe_addr_d  = pipe_addr_q;
        if (bus.enable) begin
            for (int i = 1; i < PIPE_DELAY; i++) begin
                pipe_valid_d[i] = pipe_valid_q[i-1];
                pipe_last_d[i]  = pipe_last_q[i-1];
                pipe_acc_d[i]   = pipe_acc_q[i-1];
                pipe_addr_d[i]  = pipe_addr_q[i-1];
            end
            pipe_valid_d[0] = issuing;
            pipe_last_d[0]  = last_row;
            pipe_acc_d[0]   = acc_q;
            pipe_addr_d[0]  = base_q + ADDR_WIDTH'(row_q);
            row_d           = issuing ? row_q + LEN_WIDTH'(1) : row_q;
            if (load) begin
                base_d  = bus.instr_acc_addr;
                len_d   = bus.instr_length;
                acc_d   = bus.instr_accumulate;
                row_d   = '0;
                state_d = RUN;
            end else if (state_q == RUN && last_row) begin
                state_d = |pipe_valid_d ? DRAIN : IDLE;
            end else if (state_q == DRAIN && !(|pipe_valid_d)) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            base_q       <= '0;
            len_q        <= '0;
            acc_q        <= 1'b0;
            row_q        <= '0;
            pipe_valid_q <= '0;
            pipe_last_q  <= '0;
            pipe_acc_q   <= '0;
            pipe_addr_q  <= '{default: '0};
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            len_q        <= len_d;
            acc_q        <= acc_d;
            row_q        <= row_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_last_q  <= pipe_last_d;
            pipe_acc_q   <= pipe_acc_d;
            pipe_addr_q  <= pipe_addr_d;
        end
    end

    assign bus.instr_ready       = instr_ready;
    assign bus.issue_valid       = issuing;
    assign bus.issue_first       = issuing & (row_q == '0);
    assign bus.acc_wr_en         = ~rst & bus.enable & head_valid;
    assign bus.acc_wr_addr       = pipe_addr_q[PIPE_DELAY-1];
    assign bus.acc_wr_accumulate = pipe_acc_q[PIPE_DELAY-1];
    assign bus.done              = ~rst & bus.enable & head_valid & pipe_last_q[PIPE_DELAY-1];
    assign bus.busy              = (state_q != IDLE) | (|pipe_valid_q);
endmodule

// File: tb/tb_acc_write_sequencer.sv
// tb_acc_write_sequencer: scoreboard bench with a row-list reference model
module tb_acc_write_sequencer;
    localparam int PD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    acc_write_sequencer_if #(.ADDR_WIDTH(16), .LEN_WIDTH(32)) bus ();

    acc_write_sequencer #(
        .ADDR_WIDTH(16),
        .LEN_WIDTH(32),
        .PIPE_DELAY(PD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [15:0] addr;
        logic        acc;
        logic        first;
        logic        last;
    } row_t;

    typedef struct {
        row_t r;
        int   due;
    } flight_t;

    row_t    issue_q[$];
    flight_t fl_q[$];
    int      checks   = 0;
    int      failures = 0;
    int      ecount   = 0;
    logic    accepted = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: rows become pending on acceptance, leave the pending list one
    // per enabled cycle, and are due at the write port PD enabled cycles later.
    initial begin
        row_t    r;
        flight_t f;
        logic    exp_issue;
        logic    exp_wr;
        forever begin
            @(negedge clk);
            if (rst) begin
                issue_q.delete();
                fl_q.delete();
                accepted = 1'b0;
                chk("ready_in_rst", bus.instr_ready, 0);
                chk("wr_in_rst", bus.acc_wr_en, 0);
                chk("done_in_rst", bus.done, 0);
            end else begin
                chk("busy", bus.busy, (issue_q.size() > 0 || fl_q.size() > 0));
                if (!bus.enable) begin
                    chk("stall_issue", bus.issue_valid, 0);
                    chk("stall_wr", bus.acc_wr_en, 0);
                    chk("stall_done", bus.done, 0);
                end else begin
                    ecount++;
                    chk("ready", bus.instr_ready, issue_q.size() <= 1);
                    exp_issue = issue_q.size() > 0;
                    chk("issue_valid", bus.issue_valid, exp_issue);
                    if (exp_issue && bus.issue_valid) begin
                        chk("issue_first", bus.issue_first, issue_q[0].first);
                        f.r   = issue_q[0];
                        f.due = ecount + PD;
                        fl_q.push_back(f);
                        void'(issue_q.pop_front());
                    end
                    exp_wr = fl_q.size() > 0 && fl_q[0].due == ecount;
                    chk("acc_wr_en", bus.acc_wr_en, exp_wr);
                    if (exp_wr && bus.acc_wr_en) begin
                        chk("wr_addr", bus.acc_wr_addr, fl_q[0].r.addr);
                        chk("wr_acc", bus.acc_wr_accumulate, fl_q[0].r.acc);
                        chk("done", bus.done, fl_q[0].r.last);
                        void'(fl_q.pop_front());
                    end else begin
                        chk("done_idle", bus.done, 0);
                    end
                end
                accepted = bus.instr_valid && bus.instr_ready && bus.enable;
                if (accepted) begin
                    for (longint i = 0; i < longint'(bus.instr_length); i++) begin
                        r.addr  = 16'((longint'(bus.instr_acc_addr) + i) % 65536);
                        r.acc   = bus.instr_accumulate;
                        r.first = (i == 0);
                        r.last  = (i == longint'(bus.instr_length) - 1);
                        issue_q.push_back(r);
                    end
                end
            end
        end
    end

    task automatic send(input logic [15:0] b, input logic [31:0] l, input logic a);
        bus.instr_valid      = 1'b1;
        bus.instr_acc_addr   = b;
        bus.instr_length     = l;
        bus.instr_accumulate = a;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.instr_ready && bus.enable && !rst) begin
                @(posedge clk);
                #1;
                bus.instr_valid = 1'b0;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL send_timeout: got no acceptance expected acceptance of base %0h", b);
        bus.instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                repeat (2) @(posedge clk);
                #1;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL idle_timeout: got busy=1 expected busy=0");
    endtask

    initial begin
        bus.enable           = 1'b1;
        bus.instr_valid      = 1'b0;
        bus.instr_acc_addr   = '0;
        bus.instr_length     = '0;
        bus.instr_accumulate = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", bus.instr_ready, 1);
        chk("reset_busy", bus.busy, 0);
        @(posedge clk);
        #1;
        send(16'h0010, 3, 1'b0);
        wait_idle();
        send(16'h0010, 3, 1'b0);
        send(16'h0100, 2, 1'b1);
        wait_idle();
        send(16'hFFFE, 4, 1'b0);
        wait_idle();
        send(16'h0200, 6, 1'b1);
        repeat (2) @(posedge clk);
        #1 bus.enable = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.enable = 1'b1;
        wait_idle();
        send(16'h0300, 5, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", bus.instr_ready, 1);
        chk("post_rst_busy", bus.busy, 0);
        @(posedge clk);
        #1;
        send(16'h0400, 0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        wait_idle();
        for (int c = 0; c < 600; c++) begin
            bus.enable = ($urandom_range(0, 9) < 8);
            if (!bus.instr_valid || accepted) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus.instr_valid      = 1'b1;
                    bus.instr_acc_addr   = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom);
                    bus.instr_length     = $urandom_range(0, 6);
                    bus.instr_accumulate = 1'($urandom);
                end else begin
                    bus.instr_valid = 1'b0;
                end
            end
            @(posedge clk);
            #1;
        end
        bus.instr_valid = 1'b0;
        bus.enable      = 1'b1;
        wait_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
